fetch_buffer_ctrl: RTL and testbench



---
 rtl/fetch_buffer_ctrl_if.sv | 44 ++++
 rtl/fetch_buffer_ctrl.sv | 144 ++++++++++++++
 tb/tb_fetch_buffer_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_ctrl_if.sv
// Fetch controller bus: instruction-memory request/response, decode handoff
// and redirect. The master side is the fetch controller, the slave side is
// the surrounding core/memory environment.
interface fetch_buffer_ctrl_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/fetch_buffer_ctrl.sv
// Instruction fetch sequencer: issues in-order fetch requests, buffers the
// returned words with their PCs, hands one instruction per cycle to decode,
// and flushes on redirect while discarding responses owed to flushed requests.
//
// entry state | meaning
// ------------+------------------------------------------------
// EMPTY       | slot free
// PENDING     | request accepted, PC stored, word not yet back
// FULL        | word returned, waiting for decode to pop it
module fetch_buffer_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_buffer_ctrl_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough to hold alloc + disc (up to 2*DEPTH) without overflow.
  localparam int CNT_W = $clog2(DEPTH + 1) + 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0]       st_q   [DEPTH];
  logic [1:0]       st_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [31:0]      epc_q  [DEPTH];
  logic [31:0]      epc_d  [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] disc_q, disc_d;

  logic [CNT_W-1:0] alloc_cnt;
  logic [CNT_W-1:0] pend_cnt;
  logic [CNT_W-1:0] disc_sum;
  logic             credit_ok;
  logic             req_valid;
  logic             accept;
  logic             head_full;
  logic             pop;

  // Occupancy counts derived from the per-entry states.
  always_comb begin
    alloc_cnt = '0;
    pend_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] != ST_EMPTY)   alloc_cnt = alloc_cnt + CNT_W'(1);
      if (st_q[i] == ST_PENDING) pend_cnt  = pend_cnt + CNT_W'(1);
    end
  end

  // Credit covers both live entries and responses still owed to flushed requests.
  assign credit_ok = (alloc_cnt + disc_q) < CNT_W'(DEPTH);
  assign req_valid = !reset && !bus.redirect_valid && credit_ok;
  assign accept    = req_valid && bus.imem_req_ready;
  assign head_full = (st_q[head_q] == ST_FULL);
  assign pop       = head_full && !bus.stall && !bus.redirect_valid;
  assign disc_sum  = disc_q + pend_cnt;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = head_full;
  assign bus.instr          = data_q[head_q];
  assign bus.instr_pc       = epc_q[head_q];

  // Next-state: redirect flushes everything; otherwise accept, fill and pop
  // touch distinct entries and may all happen in one cycle.
  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    epc_d  = epc_q;
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    pc_d   = pc_q;
    disc_d = disc_q;

    if (bus.redirect_valid) begin
      pc_d   = bus.redirect_pc;
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      for (int i = 0; i < DEPTH; i++) st_d[i] = ST_EMPTY;
      // A response arriving now belongs to an old request; it retires one
      // owed response. A stray response with nothing owed is ignored.
      if (bus.imem_rsp_valid && (disc_sum != '0)) disc_d = disc_sum - CNT_W'(1);
      else                                        disc_d = disc_sum;
    end else begin
      if (accept) begin
        st_d[tail_q]  = ST_PENDING;
        epc_d[tail_q] = pc_q;
        tail_d        = tail_q + PTR_W'(1);
        pc_d          = pc_q + 32'd4;
      end
      if (bus.imem_rsp_valid) begin
        if (disc_q != '0) begin
          disc_d = disc_q - CNT_W'(1);
        end else if (st_q[fill_q] == ST_PENDING) begin
          st_d[fill_q]   = ST_FULL;
          data_d[fill_q] = bus.imem_rsp_data;
          fill_d         = fill_q + PTR_W'(1);
        end
      end
      if (pop) begin
        st_d[head_q] = ST_EMPTY;
        head_d       = head_q + PTR_W'(1);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= ST_EMPTY;
        data_q[i] <= 32'h0;
        epc_q[i]  <= 32'h0;
      end
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      pc_q   <= RESET_PC;
      disc_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= st_d[i];
        data_q[i] <= data_d[i];
        epc_q[i]  <= epc_d[i];
      end
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
      pc_q   <= pc_d;
      disc_q <= disc_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer_ctrl.sv
// Directed bench for fetch_buffer_ctrl (DEPTH=2). A small in-order memory
// model returns word 0xA0 + addr/4 one cycle after acceptance when enabled.
module tb_fetch_buffer_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_buffer_ctrl_if bus ();

  fetch_buffer_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mq[$];
  bit mem_en;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_rsp();
    bus.imem_rsp_valid = mem_en && (mq.size() > 0);
    bus.imem_rsp_data  = (mem_en && (mq.size() > 0)) ? word_of(mq[0]) : 32'h0;
  endtask

  // Advance one clock; sample handshakes before the edge, update memory after.
  task automatic tick();
    logic acc, fire;
    logic [31:0] a;
    @(negedge clk);
    acc  = bus.imem_req_valid && bus.imem_req_ready;
    a    = bus.imem_req_addr;
    fire = bus.imem_rsp_valid;
    @(posedge clk);
    #1;
    if (fire && mq.size() > 0) void'(mq.pop_front());
    if (acc) mq.push_back(a);
    drive_rsp();
  endtask

  // Assert reset, check reset outputs, release; returns one step into cycle 0.
  task automatic do_reset();
    reset              = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b0;
    mq.delete();
    mem_en = 1'b0;
    drive_rsp();
    #1;
    chk("rst_req_valid",   32'(bus.imem_req_valid), 32'h0);
    chk("rst_req_addr",    bus.imem_req_addr,       32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid),    32'h0);
    chk("rst_instr",       bus.instr,               32'h0);
    chk("rst_instr_pc",    bus.instr_pc,            32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset              = 1'b0;
    bus.imem_req_ready = 1'b1;
    mem_en             = 1'b1;
    drive_rsp();
    #1;
  endtask

  initial begin
    // Streaming fetch, ready=1, 1-cycle latency
    do_reset();
    chk("t1_c0_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("t1_c0_addr",  bus.imem_req_addr,       32'h0);
    tick(); #1;
    chk("t1_c1_addr",  bus.imem_req_addr,       32'h4);
    chk("t1_c1_ivld",  32'(bus.instr_valid),    32'h0);
    tick(); #1;
    chk("t1_c2_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("t1_c2_addr",  bus.imem_req_addr,       32'h8);
    chk("t1_c2_ivld",  32'(bus.instr_valid),    32'h1);
    chk("t1_c2_ipc",   bus.instr_pc,            32'h0);
    chk("t1_c2_instr", bus.instr,               32'hA0);
    tick(); #1;
    chk("t1_c3_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("t1_c3_ipc",   bus.instr_pc,            32'h4);
    chk("t1_c3_instr", bus.instr,               32'hA1);
    tick(); #1;
    chk("t1_c4_ivld",  32'(bus.instr_valid),    32'h0);
    chk("t1_c4_addr",  bus.imem_req_addr,       32'hC);
    tick(); #1;
    chk("t1_c5_ipc",   bus.instr_pc,            32'h8);
    chk("t1_c5_instr", bus.instr,               32'hA2);

    // Decode stall for 6 cycles, then release; then ready low 3 cycles
    do_reset();
    bus.stall = 1'b1;
    #1;
    repeat (5) tick();
    #1;
    chk("t2_c5_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("t2_c5_ivld",  32'(bus.instr_valid),    32'h1);
    chk("t2_c5_ipc",   bus.instr_pc,            32'h0);
    chk("t2_c5_instr", bus.instr,               32'hA0);
    tick();
    bus.stall = 1'b0;
    #1;
    chk("t2_c6_ipc",   bus.instr_pc,            32'h0);
    chk("t2_c6_valid", 32'(bus.imem_req_valid), 32'h0);
    tick();
    bus.imem_req_ready = 1'b0;
    #1;
    chk("t2_c7_ipc",   bus.instr_pc,            32'h4);
    chk("t2_c7_instr", bus.instr,               32'hA1);
    chk("t2_c7_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("t2_c7_addr",  bus.imem_req_addr,       32'h8);
    tick(); #1;
    chk("t3_c8_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("t3_c8_addr",  bus.imem_req_addr,       32'h8);
    chk("t3_c8_ivld",  32'(bus.instr_valid),    32'h0);
    tick(); #1;
    chk("t3_c9_addr",  bus.imem_req_addr,       32'h8);
    tick();
    bus.imem_req_ready = 1'b1;
    #1;
    chk("t3_c10_addr", bus.imem_req_addr,       32'h8);
    tick(); #1;
    chk("t3_c11_addr", bus.imem_req_addr,       32'hC);
    tick(); #1;
    chk("t3_c12_ipc",  bus.instr_pc,            32'h8);
    chk("t3_c12_instr", bus.instr,              32'hA2);

    // Redirect with two requests in flight: two responses discarded
    do_reset();
    mem_en = 1'b0;
    drive_rsp();
    #1;
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    chk("t4_c2_valid", 32'(bus.imem_req_valid), 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_c3_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("t4_c3_addr",  bus.imem_req_addr,       32'h100);
    chk("t4_c3_ivld",  32'(bus.instr_valid),    32'h0);
    mem_en = 1'b1;
    drive_rsp();
    #1;
    tick(); #1;
    chk("t4_c4_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("t4_c4_addr",  bus.imem_req_addr,       32'h100);
    tick(); #1;
    chk("t4_c5_addr",  bus.imem_req_addr,       32'h104);
    chk("t4_c5_ivld",  32'(bus.instr_valid),    32'h0);
    tick(); #1;
    chk("t4_c6_ivld",  32'(bus.instr_valid),    32'h1);
    chk("t4_c6_ipc",   bus.instr_pc,            32'h100);
    chk("t4_c6_instr", bus.instr,               32'hE0);

    // Redirect coinciding with a response while head is FULL and stall=0
    do_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    #1;
    chk("t5_c2_ivld",  32'(bus.instr_valid),    32'h1);
    chk("t5_c2_ipc",   bus.instr_pc,            32'h0);
    chk("t5_c2_valid", 32'(bus.imem_req_valid), 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5_c3_ivld",  32'(bus.instr_valid),    32'h0);
    chk("t5_c3_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("t5_c3_addr",  bus.imem_req_addr,       32'h200);
    tick(); #1;
    chk("t5_c4_ivld",  32'(bus.instr_valid),    32'h0);
    tick(); #1;
    chk("t5_c5_ipc",   bus.instr_pc,            32'h200);
    chk("t5_c5_instr", bus.instr,               32'h120);

    // Credit exhausted with one live entry and one owed response, then reset
    do_reset();
    mem_en = 1'b0;
    drive_rsp();
    #1;
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    #1;
    tick();
    bus.redirect_valid = 1'b0;
    mem_en = 1'b1;
    drive_rsp();
    #1;
    tick();
    mem_en = 1'b0;
    drive_rsp();
    #1;
    chk("t6_c4_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("t6_c4_addr",  bus.imem_req_addr,       32'h300);
    tick(); #1;
    chk("t6_c5_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("t6_c5_addr",  bus.imem_req_addr,       32'h304);
    do_reset();
    chk("t6_r_addr",   bus.imem_req_addr,       32'h0);
    tick();
    tick(); #1;
    chk("t6_r_ivld",   32'(bus.instr_valid),    32'h1);
    chk("t6_r_ipc",    bus.instr_pc,            32'h0);
    chk("t6_r_instr",  bus.instr,               32'hA0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
